// File: rtl/axis_mem_fifo.sv
// Single-clock AXI-Stream FIFO on an internal RAM array, with level and almost-full reporting.
// Define AXIS_MEM_FIFO_PKT_MODE_EN to build the store-and-forward packet mode.
module axis_mem_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [ADDR_WIDTH:0]       level,
    output logic                      almost_full,
    output logic                      oversize_err
);
    // Handshake: a beat moves on a rising clk edge where tvalid and tready are
    // both high; tvalid is a function of stored state only, never of tready.

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WORD_W = DATA_WIDTH + STRB_W + 1;

    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_L = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   ONE_L   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = (ADDR_WIDTH)'(1);

    logic [WORD_W-1:0]     r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_tready;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_tvalid;
    logic [ADDR_WIDTH:0]   w_next_level;
    logic [WORD_W-1:0]     w_head;
    logic                  w_head_last;

    assign w_push      = s_axis_tvalid & r_tready;
    assign w_pop       = w_tvalid & m_axis_tready;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_last = w_head[WORD_W-1];

    always_comb begin
        w_next_level = r_level;
        case ({w_push, w_pop})
            2'b10:   w_next_level = r_level + ONE_L;
            2'b01:   w_next_level = r_level - ONE_L;
            default: w_next_level = r_level;
        endcase
    end

    // RAM is deliberately not reset; outputs are don't-care while tvalid is low.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_tready <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_level  <= w_next_level;
            // A pop while full only reopens the input on the following cycle.
            r_tready <= (w_next_level != DEPTH_L);
        end
    end

`ifdef AXIS_MEM_FIFO_PKT_MODE_EN
    logic [ADDR_WIDTH:0] r_pkt_cnt;
    logic                r_release;
    logic                r_oversize;
    logic                w_push_last;
    logic                w_pop_last;

    assign w_push_last = w_push & s_axis_tlast;
    assign w_pop_last  = w_pop & w_head_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt  <= '0;
            r_release  <= 1'b0;
            r_oversize <= 1'b0;
        end else begin
            case ({w_push_last, w_pop_last})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + ONE_L;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - ONE_L;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
            // A full FIFO with no complete packet can never drain unless we cut through.
            if (w_pop_last) begin
                r_release <= 1'b0;
            end else if ((r_level == DEPTH_L) && (r_pkt_cnt == '0)) begin
                r_release  <= 1'b1;
                r_oversize <= 1'b1;
            end
        end
    end

    assign w_tvalid     = (r_level != '0) & ((r_pkt_cnt != '0) | r_release);
    assign oversize_err = r_oversize;
`else
    assign w_tvalid     = (r_level != '0);
    assign oversize_err = 1'b0;
`endif

    assign s_axis_tready = r_tready;
    assign m_axis_tvalid = w_tvalid;
    assign m_axis_tdata  = w_head[DATA_WIDTH-1:0];
    assign m_axis_tstrb  = w_head[DATA_WIDTH +: STRB_W];
    assign m_axis_tlast  = w_head_last;
    assign level         = r_level;
    assign almost_full   = (r_level >= AFULL_L);

endmodule

// File: tb/tb_axis_mem_fifo.sv
// Directed self-checking bench for axis_mem_fifo (default parameters, 16-entry FIFO).
module tb_axis_mem_fifo;
  logic        clk;
  logic        rst;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [4:0]  level;
  logic        almost_full;
  logic        oversize_err;

  int n_checks;
  int n_fail;

  axis_mem_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .level(level), .almost_full(almost_full), .oversize_err(oversize_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tstrb = 4'hF; s_tdata = '0; m_tready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // driver: present one beat for one edge (caller checks tready beforehand)
  task automatic push_beat(input logic [31:0] d, input logic [3:0] st, input logic la);
    s_tdata = d; s_tstrb = st; s_tlast = la; s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tstrb = 4'hF; s_tdata = '0; m_tready = 1'b0;
    step();
    step();
    n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b want 0", s_tready); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", level); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_afull: got %b want 0", almost_full); end
    n_checks++; if (oversize_err !== 1'b0) begin n_fail++; $display("FAIL rst_oversize: got %b want 0", oversize_err); end
    rst = 1'b0;
    #1;
    n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rel_tready_early: got %b want 0", s_tready); end
    step();
    n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL rel_tready: got %b want 1", s_tready); end
    push_beat(32'hA5A5_0001, 4'hF, 1'b1);
`ifdef AXIS_MEM_FIFO_PKT_MODE_EN
    n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL t1_tvalid: got %b want 1", m_tvalid); end
`else
    n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL t1_tvalid: got %b want 1", m_tvalid); end
`endif
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL t1_level: got %0d want 1", level); end
    n_checks++; if (m_tdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL t1_data: got %h want a5a50001", m_tdata); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL fill_tready_pre%0d: got %b want 1", i, s_tready); end
      push_beat(32'h100 + 32'(i), 4'hF, 1'b1);
      n_checks++; if (level !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_level%0d: got %0d want %0d", i, level, i + 1); end
      n_checks++; if (almost_full !== ((i + 1) >= 12)) begin n_fail++; $display("FAIL fill_afull%0d: got %b want %b", i, almost_full, ((i + 1) >= 12)); end
    end
    n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL full_tready: got %b want 0", s_tready); end
    n_checks++; if (m_tdata !== 32'h100) begin n_fail++; $display("FAIL full_head: got %h want 100", m_tdata); end
    // pop while a push is offered: the push must not be admitted this cycle
    s_tdata = 32'hDEAD; s_tvalid = 1'b1; m_tready = 1'b1;
    step();
    s_tvalid = 1'b0; m_tready = 1'b0;
    n_checks++; if (level !== 5'd15) begin n_fail++; $display("FAIL fullpop_level: got %0d want 15", level); end
    n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL fullpop_tready: got %b want 1", s_tready); end
    n_checks++; if (m_tdata !== 32'h101) begin n_fail++; $display("FAIL fullpop_head: got %h want 101", m_tdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    do_reset();
    exp_q.push_back(32'd0);
    push_beat(32'd0, 4'hF, 1'b1);
    m_tready = 1'b1;
    for (int i = 1; i < 40; i++) begin
      s_tdata = 32'(i); s_tstrb = 4'hF; s_tlast = 1'b1; s_tvalid = 1'b1;
      exp_q.push_back(32'(i));
      exp_v = exp_q.pop_front();
      n_checks++; if (m_tdata !== exp_v) begin n_fail++; $display("FAIL b2b_data%0d: got %0d want %0d", i, m_tdata, exp_v); end
      n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL b2b_level%0d: got %0d want 1", i, level); end
      step();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    exp_v = exp_q.pop_front();
    n_checks++; if (m_tdata !== exp_v) begin n_fail++; $display("FAIL b2b_last: got %0d want %0d", m_tdata, exp_v); end
    step();
    m_tready = 1'b0;
    n_checks++; if (level !== 5'd0 || m_tvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got level %0d tvalid %b want 0 0", level, m_tvalid); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 7; i++) push_beat(32'h70 + 32'(i), 4'hF, 1'b1);
    n_checks++; if (level !== 5'd7) begin n_fail++; $display("FAIL mr_level_pre: got %0d want 7", level); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mr_tvalid: got %b want 0", m_tvalid); end
    n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL mr_tready: got %b want 0", s_tready); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL mr_level: got %0d want 0", level); end
    step();
    rst = 1'b0;
    step();
    push_beat(32'h55, 4'h1, 1'b1);
    n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h55) begin n_fail++; $display("FAIL mr_first: got tvalid %b data %h want 1 55", m_tvalid, m_tdata); end
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL mr_level_post: got %0d want 1", level); end
  endtask

  task automatic test_packet();
    logic [31:0] exp_d [3];
    logic [3:0]  exp_s [3];
    exp_d[0] = 32'hC0; exp_d[1] = 32'hC1; exp_d[2] = 32'hC2;
    exp_s[0] = 4'hF;   exp_s[1] = 4'h3;   exp_s[2] = 4'h8;
    do_reset();
    push_beat(exp_d[0], exp_s[0], 1'b0);
`ifdef AXIS_MEM_FIFO_PKT_MODE_EN
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL pkt_hold1: got %b want 0", m_tvalid); end
`else
    n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL pkt_cut1: got %b want 1", m_tvalid); end
`endif
    push_beat(exp_d[1], exp_s[1], 1'b0);
`ifdef AXIS_MEM_FIFO_PKT_MODE_EN
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL pkt_hold2: got %b want 0", m_tvalid); end
`endif
    push_beat(exp_d[2], exp_s[2], 1'b1);
    n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL pkt_ready: got %b want 1", m_tvalid); end
    m_tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (m_tdata !== exp_d[k] || m_tstrb !== exp_s[k] || m_tlast !== (k == 2)) begin
        n_fail++; $display("FAIL pkt_beat%0d: got %h/%h/%b want %h/%h/%b", k, m_tdata, m_tstrb, m_tlast, exp_d[k], exp_s[k], (k == 2));
      end
      step();
    end
    m_tready = 1'b0;
    n_checks++; if (m_tvalid !== 1'b0 || level !== 5'd0) begin n_fail++; $display("FAIL pkt_empty: got tvalid %b level %0d want 0 0", m_tvalid, level); end
  endtask

  task automatic test_oversize();
    do_reset();
    for (int i = 0; i < 16; i++) push_beat(32'h200 + 32'(i), 4'hF, 1'b0);
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL os_level: got %0d want 16", level); end
    step();
`ifdef AXIS_MEM_FIFO_PKT_MODE_EN
    n_checks++; if (oversize_err !== 1'b1) begin n_fail++; $display("FAIL os_err: got %b want 1", oversize_err); end
    n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL os_cut: got %b want 1", m_tvalid); end
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    n_checks++; if (level !== 5'd15 || s_tready !== 1'b1) begin n_fail++; $display("FAIL os_pop: got level %0d tready %b want 15 1", level, s_tready); end
    push_beat(32'h2FF, 4'hF, 1'b1);
    m_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== ((k == 15) ? 32'h2FF : 32'h201 + 32'(k)) || m_tlast !== (k == 15)) begin
        n_fail++; $display("FAIL os_drain%0d: got %b/%h/%b want 1/%h/%b", k, m_tvalid, m_tdata, m_tlast, ((k == 15) ? 32'h2FF : 32'h201 + 32'(k)), (k == 15));
      end
      step();
    end
    m_tready = 1'b0;
    push_beat(32'h300, 4'hF, 1'b0);
    n_checks++; if (m_tvalid !== 1'b0 || level !== 5'd1) begin n_fail++; $display("FAIL os_rehold: got tvalid %b level %0d want 0 1", m_tvalid, level); end
    push_beat(32'h301, 4'hF, 1'b1);
    n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h300) begin n_fail++; $display("FAIL os_release: got %b/%h want 1/300", m_tvalid, m_tdata); end
    n_checks++; if (oversize_err !== 1'b1) begin n_fail++; $display("FAIL os_sticky: got %b want 1", oversize_err); end
`else
    n_checks++; if (oversize_err !== 1'b0) begin n_fail++; $display("FAIL os_tied: got %b want 0", oversize_err); end
    n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h200) begin n_fail++; $display("FAIL os_plain: got %b/%h want 1/200", m_tvalid, m_tdata); end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_fill();
    test_back_to_back();
    test_mid_reset();
    test_packet();
    test_oversize();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
